// File: rtl/ibex_instr_bus_arbiter.sv
// Two-requester instruction-port arbiter with bus lock until grant and in-order response routing.
// Optional macro IBEX_INSTR_ARB_ROUND_ROBIN_EN: alternate winners on simultaneous requests.
module ibex_instr_bus_arbiter #(
    parameter int NUM_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        r0_req_i,
    input  logic [31:0] r0_addr_i,
    output logic        r0_gnt_o,
    output logic        r0_rvalid_o,
    output logic [31:0] r0_rdata_o,
    output logic        r0_err_o,
    input  logic        r1_req_i,
    input  logic [31:0] r1_addr_i,
    output logic        r1_gnt_o,
    output logic        r1_rvalid_o,
    output logic [31:0] r1_rdata_o,
    output logic        r1_err_o,
    output logic        bus_req_o,
    output logic [31:0] bus_addr_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_err_i,
    output logic        busy_o,
    output logic        protocol_err_o
);
    localparam int PW = (NUM_OUTSTANDING > 1) ? $clog2(NUM_OUTSTANDING) : 1;
    localparam int CW = $clog2(NUM_OUTSTANDING + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(NUM_OUTSTANDING);
    localparam logic [PW-1:0] PTR_LAST = PW'(NUM_OUTSTANDING - 1);

    logic                       locked_q, locked_d;
    logic                       owner_q, owner_d;
    logic                       perr_q, perr_d;
    logic [CW-1:0]              count_q, count_d;
    logic [PW-1:0]              wptr_q, wptr_d, rptr_q, rptr_d;
    logic [NUM_OUTSTANDING-1:0] route_q, route_d;
`ifdef IBEX_INSTR_ARB_ROUND_ROBIN_EN
    logic                       last_q, last_d;
`endif

    logic sel, sel_req, issue, grant, pop, head;

    always_comb begin
        if (locked_q) begin
            sel = owner_q;
        end else if (r0_req_i && r1_req_i) begin
`ifdef IBEX_INSTR_ARB_ROUND_ROBIN_EN
            sel = ~last_q;
`else
            sel = 1'b0;
`endif
        end else begin
            sel = r1_req_i & ~r0_req_i;
        end
        sel_req = sel ? r1_req_i : r0_req_i;
        // No bypass: a slot freed by this cycle's rvalid is usable only next cycle.
        issue   = sel_req & (count_q != CNT_MAX) & ~rst_i;
        grant   = issue & bus_gnt_i;
        pop     = bus_rvalid_i & (count_q != '0) & ~rst_i;
        head    = route_q[rptr_q];
    end

    always_comb begin
        locked_d = locked_q;
        owner_d  = owner_q;
        perr_d   = perr_q;
        count_d  = count_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        route_d  = route_q;
`ifdef IBEX_INSTR_ARB_ROUND_ROBIN_EN
        last_d   = last_q;
`endif
        if (grant) begin
            locked_d        = 1'b0;
            route_d[wptr_q] = sel;
            wptr_d          = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
`ifdef IBEX_INSTR_ARB_ROUND_ROBIN_EN
            last_d          = sel;
`endif
        end else if (issue) begin
            locked_d = 1'b1;
            owner_d  = sel;
        end else if (locked_q && !sel_req) begin
            locked_d = 1'b0;
            perr_d   = 1'b1;
        end
        if (pop) begin
            rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
        end
        if (bus_rvalid_i && count_q == '0) begin
            perr_d = 1'b1;
        end
        if (grant && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !grant) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            locked_q <= 1'b0;
            owner_q  <= 1'b0;
            perr_q   <= 1'b0;
            count_q  <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            route_q  <= '0;
`ifdef IBEX_INSTR_ARB_ROUND_ROBIN_EN
            last_q   <= 1'b1;
`endif
        end else begin
            locked_q <= locked_d;
            owner_q  <= owner_d;
            perr_q   <= perr_d;
            count_q  <= count_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            route_q  <= route_d;
`ifdef IBEX_INSTR_ARB_ROUND_ROBIN_EN
            last_q   <= last_d;
`endif
        end
    end

    // Every output reads zero while reset is held.
    assign bus_req_o      = issue;
    assign bus_addr_o     = rst_i ? 32'h0 : {(sel ? r1_addr_i[31:2] : r0_addr_i[31:2]), 2'b00};
    assign r0_gnt_o       = grant & ~sel;
    assign r1_gnt_o       = grant & sel;
    assign r0_rvalid_o    = pop & ~head;
    assign r1_rvalid_o    = pop & head;
    assign r0_rdata_o     = rst_i ? 32'h0 : bus_rdata_i;
    assign r1_rdata_o     = rst_i ? 32'h0 : bus_rdata_i;
    assign r0_err_o       = bus_err_i & ~rst_i;
    assign r1_err_o       = bus_err_i & ~rst_i;
    assign busy_o         = (issue | (count_q != '0)) & ~rst_i;
    assign protocol_err_o = perr_q & ~rst_i;
endmodule

// File: tb/tb_ibex_instr_bus_arbiter.sv
// Directed + randomized bench for ibex_instr_bus_arbiter against a queue-based reference model.
module tb_ibex_instr_bus_arbiter;
    localparam int N = 2;

    logic        clk_i = 1'b0, rst_i = 1'b0;
    logic        r0_req_i = 0, r1_req_i = 0, bus_gnt_i = 0, bus_rvalid_i = 0, bus_err_i = 0;
    logic [31:0] r0_addr_i = 0, r1_addr_i = 0, bus_rdata_i = 0;
    logic        r0_gnt_o, r0_rvalid_o, r0_err_o, r1_gnt_o, r1_rvalid_o, r1_err_o;
    logic        bus_req_o, busy_o, protocol_err_o;
    logic [31:0] r0_rdata_o, r1_rdata_o, bus_addr_o;

    ibex_instr_bus_arbiter #(.NUM_OUTSTANDING(N)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .r0_req_i(r0_req_i), .r0_addr_i(r0_addr_i), .r0_gnt_o(r0_gnt_o),
        .r0_rvalid_o(r0_rvalid_o), .r0_rdata_o(r0_rdata_o), .r0_err_o(r0_err_o),
        .r1_req_i(r1_req_i), .r1_addr_i(r1_addr_i), .r1_gnt_o(r1_gnt_o),
        .r1_rvalid_o(r1_rvalid_o), .r1_rdata_o(r1_rdata_o), .r1_err_o(r1_err_o),
        .bus_req_o(bus_req_o), .bus_addr_o(bus_addr_o), .bus_gnt_i(bus_gnt_i),
        .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i),
        .busy_o(busy_o), .protocol_err_o(protocol_err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0, n_fail = 0;

    // Reference model: who is waiting for a grant, and who owns each outstanding request.
    int m_pend = -1;
    int m_q[$];
    int m_last = 0;
    bit m_perr = 0;
    int e_sel;
    bit e_issue;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = -1;
        m_q.delete();
        m_perr = 0;
`ifdef IBEX_INSTR_ARB_ROUND_ROBIN_EN
        m_last = 1;
`else
        m_last = 0;
`endif
    endtask

    task automatic drive(input bit q0, input logic [31:0] a0, input bit q1, input logic [31:0] a1,
                         input bit g, input bit rv, input logic [31:0] rd, input bit er);
        r0_req_i = q0; r0_addr_i = a0; r1_req_i = q1; r1_addr_i = a1;
        bus_gnt_i = g; bus_rvalid_i = rv; bus_rdata_i = rd; bus_err_i = er;
        #2;
    endtask

    // Compare every output with what the model predicts for the current inputs.
    task automatic check_model();
        int head;
        bit sreq;
        logic [31:0] a;
        if (m_pend >= 0) e_sel = m_pend;
        else if (r0_req_i && r1_req_i) begin
`ifdef IBEX_INSTR_ARB_ROUND_ROBIN_EN
            e_sel = (m_last == 0) ? 1 : 0;
`else
            e_sel = 0;
`endif
        end else e_sel = r1_req_i ? 1 : 0;
        sreq    = (e_sel == 1) ? r1_req_i : r0_req_i;
        e_issue = sreq && (m_q.size() < N);
        head    = (m_q.size() > 0) ? m_q[0] : -1;
        a       = (e_sel == 1) ? r1_addr_i : r0_addr_i;
        a[1:0]  = 2'b00;
        chk("bus_req", bus_req_o, e_issue);
        chk("bus_addr", bus_addr_o, a);
        chk("r0_gnt", r0_gnt_o, e_issue && bus_gnt_i && e_sel == 0);
        chk("r1_gnt", r1_gnt_o, e_issue && bus_gnt_i && e_sel == 1);
        chk("r0_rvalid", r0_rvalid_o, bus_rvalid_i && head == 0);
        chk("r1_rvalid", r1_rvalid_o, bus_rvalid_i && head == 1);
        chk("r0_rdata", r0_rdata_o, bus_rdata_i);
        chk("r1_rdata", r1_rdata_o, bus_rdata_i);
        chk("r0_err", r0_err_o, bus_err_i);
        chk("r1_err", r1_err_o, bus_err_i);
        chk("busy", busy_o, e_issue || m_q.size() > 0);
        chk("perr", protocol_err_o, m_perr);
    endtask

    task automatic tick();
        bit sreq;
        sreq = (e_sel == 1) ? r1_req_i : r0_req_i;
        if (bus_rvalid_i) begin
            if (m_q.size() > 0) void'(m_q.pop_front());
            else m_perr = 1;
        end
        if (e_issue && bus_gnt_i) begin
            m_pend = -1; m_q.push_back(e_sel); m_last = e_sel;
        end else if (e_issue) m_pend = e_sel;
        else if (m_pend >= 0 && !sreq) begin
            m_pend = -1; m_perr = 1;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        drive(1, $urandom, 1, $urandom, 1, 1, $urandom, 1);
        model_reset();
        chk("rst_bus_req", bus_req_o, 0);
        chk("rst_bus_addr", bus_addr_o, 0);
        chk("rst_gnt", {r0_gnt_o, r1_gnt_o}, 0);
        chk("rst_rvalid", {r0_rvalid_o, r1_rvalid_o}, 0);
        chk("rst_rdata", r0_rdata_o | r1_rdata_o, 0);
        chk("rst_err", {r0_err_o, r1_err_o}, 0);
        chk("rst_busy_perr", {busy_o, protocol_err_o}, 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check_model();
        tick();
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && m_q.size() > 0; i++) begin
            drive(0, 0, 0, 0, 0, 1, $urandom, 0);
            check_model();
            tick();
        end
        chk("drain_empty", busy_o, 0);
    endtask

    initial begin
        #1;
        do_reset();

        // Single requester, misaligned address, response next cycle.
        drive(1, 32'h1000_0006, 0, 0, 1, 0, 0, 0); check_model();
        chk("t1_addr", bus_addr_o, 32'h1000_0004);
        chk("t1_gnt0", r0_gnt_o, 1);
        tick();
        drive(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0); check_model();
        chk("t1_rv0", r0_rvalid_o, 1);
        chk("t1_rdata", r0_rdata_o, 32'hDEAD_BEEF);
        chk("t1_rv1", r1_rvalid_o, 0);
        tick();

        // r1 locks the bus while grant is withheld, r0 joins from cycle 1.
        for (int c = 0; c < 5; c++) begin
            drive(c != 0, 32'h0000_A000, 1, 32'h0000_B008, c >= 3, 0, 0, 0); check_model();
            if (c < 4) chk("t2_addr_r1", bus_addr_o, 32'h0000_B008);
            if (c == 3) chk("t2_gnt1", r1_gnt_o, 1);
            if (c < 3) chk("t2_nognt", {r0_gnt_o, r1_gnt_o}, 0);
            if (c == 4) chk("t2_r0_sel", {bus_addr_o, r0_gnt_o}, {32'h0000_A000, 1'b1});
            tick();
        end
        drain();

        // Fill the route queue, then one rvalid reopens issue a cycle later.
        for (int c = 0; c < 5; c++) begin
            drive(1, 32'h2000_0000 + c * 4, 0, 0, 1, c == 3, $urandom, 0); check_model();
            if (c == 2 || c == 3) chk("t3_full_noreq", {bus_req_o, busy_o}, 2'b01);
            if (c == 4) chk("t3_reopen", bus_req_o, 1);
            tick();
        end
        drain();

        // Interleaved routing with an error on the second response.
        drive(1, 32'h100, 0, 0, 1, 0, 0, 0); check_model(); tick();
        drive(0, 0, 1, 32'h200, 1, 0, 0, 0); check_model(); tick();
        drive(0, 0, 0, 0, 0, 1, 32'h1111_1111, 0); check_model();
        chk("t4_first_r0", {r0_rvalid_o, r1_rvalid_o}, 2'b10);
        tick();
        drive(0, 0, 0, 0, 0, 1, 32'h2222_2222, 1); check_model();
        chk("t4_second_r1", {r0_rvalid_o, r1_rvalid_o, r1_err_o}, 3'b011);
        tick();

        // Continuous contention with grant always high.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive(1, 32'h300, 1, 32'h400, 1, c != 0, $urandom, 0); check_model();
`ifdef IBEX_INSTR_ARB_ROUND_ROBIN_EN
            chk("t5_rr", {r0_gnt_o, r1_gnt_o}, (c == 1) ? 2'b01 : 2'b10);
`else
            chk("t5_fixed", {r0_gnt_o, r1_gnt_o}, 2'b10);
`endif
            tick();
        end
        drain();

        // Spurious rvalid sets a sticky error; reset clears it.
        drive(0, 0, 0, 0, 0, 1, 0, 0); check_model(); tick();
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0); check_model();
            chk("t6_sticky", protocol_err_o, 1);
            tick();
        end
        do_reset();
        chk("t6_cleared", protocol_err_o, 0);
        drive(1, 32'h500, 0, 0, 1, 0, 0, 0); check_model(); tick();
        do_reset();
        drive(0, 0, 0, 0, 0, 1, 0, 0); check_model(); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0); check_model();
        chk("t6_stale_rvalid", protocol_err_o, 1);
        tick();

        // Randomized traffic with periodic resets.
        for (int c = 0; c < 600; c++) begin
            if (c % 100 == 0) do_reset();
            drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) == 0, $urandom,
                  $urandom_range(0, 2) != 0,
                  (m_q.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 40) == 0),
                  $urandom, $urandom_range(0, 7) == 0);
            check_model();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
